vlc_fifo_tx: RTL and testbench
==============================

VLC_FIFO_TX -- requirements
Module: vlc_fifo_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: clock cycles per Manchester half-bit; legal range 1..255.
REQ-002 Parameter MAX_WORDS, default 16: maximum payload words per frame; legal range 1..255.
REQ-003 Parameter SYNC, default 16'hAAD5: 16-bit frame header, sent MSB first.
REQ-004 Parameter GAP_BITS, default 8: idle bit periods after each frame; legal range 1..255.
REQ-005 iClock  in  1  single clock; all logic on its rising edge.
REQ-006 iRst_n  in  1  reset, asynchronous, active-low.
REQ-007 iEnable  in  1  allows a new frame to start.
REQ-008 iEmpty  in  1  FIFO empty flag, read-side.
REQ-009 iRdusewd  in  11  FIFO read-side word count.
REQ-010 iData  in  32  FIFO read data; valid one cycle after the oRead pulse.
REQ-011 oRead  out  1  FIFO pop request, single-cycle pulse.
REQ-012 oTx  out  1  registered Manchester line output to the LED driver.
REQ-013 oBusy  out  1  high from frame start to end of GAP.
REQ-014 oFrameDone  out  1  one-cycle pulse when the last payload bit completes.
REQ-015 oUnderrun  out  1  one-cycle pulse when a prefetch finds iEmpty high.

Function
REQ-016 FSM states: IDLE, SYNC, LEN, DATA, GAP.
REQ-017 IDLE -> SYNC when iEnable=1 and iEmpty=0; same cycle: latch N = min(max(iRdusewd,1), MAX_WORDS) and pulse oRead for word 0.
REQ-018 iData shall be captured into the next-word buffer on the cycle after each oRead pulse.
REQ-019 SYNC sends 16 bits; LEN sends N as 8 bits; DATA sends N words, 32 bits each; all MSB first, no idle between fields or words.
REQ-020 On loading word k into the shift register, if k+1 < N: pulse oRead when iEmpty=0; otherwise suppress oRead, pulse oUnderrun, finish word k, then enter GAP.
REQ-021 oRead shall never be asserted while iEmpty=1; oRead pulses per frame = N, fewer only on underrun.
REQ-022 Manchester encoding: bit 1 = high half then low half; bit 0 = low half then high half; each half lasts CLK_DIV cycles.
REQ-023 Bit period = 2*CLK_DIV cycles; frame length = (24 + 32N) bit periods + GAP_BITS.
REQ-024 The half-bit timer restarts on IDLE->SYNC, so the first half-bit begins on the cycle after the start decision.
REQ-025 oFrameDone pulses on the final half-bit edge of the last transmitted word, including a shortened frame; GAP follows.
REQ-026 GAP holds oTx=0 for GAP_BITS bit periods, then returns to IDLE; back-to-back frames are allowed.
REQ-027 IDLE holds oTx=0 and oBusy=0.
REQ-028 iEnable falling mid-frame shall not truncate the frame; it only blocks the next start.

Reset
REQ-029 Asserting iRst_n low, in any state, shall immediately force IDLE with oTx=0, oRead=0, oBusy=0, oFrameDone=0, oUnderrun=0, and all counters and buffers zeroed.
REQ-030 Words already popped when reset occurs mid-frame are discarded; the next frame starts from a full SYNC.

Structure
REQ-031 Package vlc_pkg shall hold the FSM state enum, the SYNC default, and the field widths (SYNC 16, LEN 8, WORD 32).
REQ-032 Sub-module vlc_bit_tick shall hold the CLK_DIV divider; it produces half-bit and bit-end strobes and is restartable.

Verification
REQ-033 CLK_DIV=4, FIFO holds 0xDEADBEEF, iRdusewd=1 -> one oRead pulse; decoded bits AAD5, 01, DEADBEEF; 56 bits in 448 cycles; oFrameDone pulse; 64 cycles of oTx=0.
REQ-034 FIFO holds 40 words, MAX_WORDS=16 -> three frames with LEN 0x10, 0x10, 0x08; 40 oRead pulses total; payload order preserved.
REQ-035 iRdusewd=3, iEmpty forced high after first pop -> oUnderrun pulses once; no oRead while iEmpty=1; frame ends after word 0; oTx=0 during GAP.
REQ-036 iRst_n low mid-DATA -> oTx=0 and oBusy=0 asynchronously; after release with FIFO non-empty, a new frame begins with SYNC.
REQ-037 iEnable dropped during LEN -> current frame completes with oFrameDone; no further frame starts while iEnable=0.
REQ-038 Word 0x00000001, CLK_DIV=1 -> the last two payload bit periods on oTx are 0,1 (bit 0) then 1,0 (bit 1).

Source files
------------

// File: rtl/vlc_pkg.sv
// vlc_pkg: shared FSM states, field widths and helpers for the VLC Manchester transmitter.
package vlc_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_LEN, ST_DATA, ST_GAP} state_e;
    localparam int SYNC_W = 16;
    localparam int LEN_W  = 8;
    localparam int WORD_W = 32;
    localparam logic [SYNC_W-1:0] SYNC_DEFAULT = 16'hAAD5;
    // Words in a frame: at least one, never more than max_words.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [10:0] used, input int max_words);
        return (used == 11'd0) ? 8'd1 : (int'(used) > max_words) ? 8'(max_words) : used[7:0];
    endfunction
endpackage

// File: rtl/vlc_bit_tick.sv
// vlc_bit_tick: restartable CLK_DIV divider producing half-bit and bit-end strobes.
module vlc_bit_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic iClock,
    input  logic iRst_n,
    input  logic iRestart,
    input  logic iRun,
    output logic oHalf,
    output logic oBitEnd,
    output logic oPhase
);
    logic [7:0] cnt_q, cnt_d;
    logic       ph_q, ph_d;
    logic       hold;
    assign hold    = iRestart || !iRun;
    assign oHalf   = !hold && cnt_q == 8'(CLK_DIV - 1);
    assign oBitEnd = oHalf && ph_q;
    assign oPhase  = ph_q;
    assign cnt_d   = (hold || oHalf) ? 8'd0 : cnt_q + 8'd1;
    assign ph_d    = hold ? 1'b0 : ph_q ^ oHalf;
    always_ff @(posedge iClock or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q <= 8'd0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end
endmodule

// File: rtl/vlc_fifo_tx.sv
// vlc_fifo_tx: pops words from a FIFO and sends SYNC, LEN and payload as Manchester on an LED line.
module vlc_fifo_tx import vlc_pkg::*; #(
    parameter int                CLK_DIV   = 4,
    parameter int                MAX_WORDS = 16,
    parameter logic [SYNC_W-1:0] SYNC      = SYNC_DEFAULT,
    parameter int                GAP_BITS  = 8
) (
    input  logic        iClock,
    input  logic        iRst_n,
    input  logic        iEnable,
    input  logic        iEmpty,
    input  logic [10:0] iRdusewd,
    input  logic [31:0] iData,
    output logic        oRead,
    output logic        oTx,
    output logic        oBusy,
    output logic        oFrameDone,
    output logic        oUnderrun
);
    state_e      state_q;
    logic [7:0]  n_q, widx_q, gap_q, next_k;
    logic [4:0]  bits_q;
    logic [31:0] sh_q, buf_q;
    logic        rd_pend_q, last_q, tx_q, busy_q, done_q, under_q;
    logic        half, bit_end, phase, start, field_end, load, more;

    vlc_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .iClock  (iClock),
        .iRst_n  (iRst_n),
        .iRestart(start),
        .iRun    (state_q != ST_IDLE),
        .oHalf   (half),
        .oBitEnd (bit_end),
        .oPhase  (phase)
    );

    assign start     = state_q == ST_IDLE && iEnable && !iEmpty;
    assign field_end = bit_end && bits_q == 5'd0;
    assign load      = field_end && (state_q == ST_LEN || (state_q == ST_DATA && !last_q));
    assign next_k    = (state_q == ST_LEN) ? 8'd0 : widx_q + 8'd1;
    assign more      = {1'b0, next_k} + 9'd1 < {1'b0, n_q};
    // Pops are combinational so they can be gated by the current empty flag.
    assign oRead      = iRst_n && (start || (load && more && !iEmpty));
    assign oTx        = tx_q;
    assign oBusy      = busy_q;
    assign oFrameDone = done_q;
    assign oUnderrun  = under_q;

    always_ff @(posedge iClock or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= ST_IDLE;
            n_q       <= 8'd0;
            widx_q    <= 8'd0;
            gap_q     <= 8'd0;
            bits_q    <= 5'd0;
            sh_q      <= 32'd0;
            buf_q     <= 32'd0;
            rd_pend_q <= 1'b0;
            last_q    <= 1'b0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            rd_pend_q <= oRead;
            if (rd_pend_q) buf_q <= iData;
            done_q  <= 1'b0;
            under_q <= load && more && iEmpty;
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q <= ST_SYNC;
                    n_q     <= clamp_len(iRdusewd, MAX_WORDS);
                    sh_q    <= {SYNC, {(WORD_W-SYNC_W){1'b0}}};
                    bits_q  <= 5'(SYNC_W - 1);
                    tx_q    <= SYNC[SYNC_W-1];
                    busy_q  <= 1'b1;
                    last_q  <= 1'b0;
                end
                ST_GAP: if (bit_end) begin
                    if (gap_q == 8'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else gap_q <= gap_q - 8'd1;
                end
                default: if (half && !phase) tx_q <= ~sh_q[31];
                else if (bit_end && bits_q != 5'd0) begin
                    sh_q   <= {sh_q[30:0], 1'b0};
                    bits_q <= bits_q - 5'd1;
                    tx_q   <= sh_q[30];
                end else if (bit_end && state_q == ST_SYNC) begin
                    state_q <= ST_LEN;
                    sh_q    <= {n_q, {(WORD_W-LEN_W){1'b0}}};
                    bits_q  <= 5'(LEN_W - 1);
                    tx_q    <= n_q[7];
                end else if (load) begin
                    // A missing next word marks this one as the last of a shortened frame.
                    state_q <= ST_DATA;
                    sh_q    <= buf_q;
                    bits_q  <= 5'(WORD_W - 1);
                    tx_q    <= buf_q[31];
                    widx_q  <= next_k;
                    last_q  <= !more || iEmpty;
                end else if (bit_end) begin
                    state_q <= ST_GAP;
                    tx_q    <= 1'b0;
                    done_q  <= 1'b1;
                    gap_q   <= 8'(GAP_BITS - 1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vlc_fifo_tx.sv
// tb_vlc_fifo_tx: random and directed frames checked cycle by cycle against a timing model of the line.
module tb_vlc_fifo_tx;
    localparam int CD = 4, MW = 16, GB = 8, P = 2 * CD;
    localparam logic [15:0] SY = 16'hAAD5;

    logic clk = 0, rst_n = 0, en = 0, empty = 1;
    logic rd, tx, busy, done, und;
    logic [10:0] used = 0;
    logic [31:0] data = 0;
    logic en1 = 0, empty1 = 1, rd1, tx1, busy1, done1, und1;
    logic [31:0] data1 = 0;

    always #5 clk = ~clk;

    vlc_fifo_tx #(.CLK_DIV(CD), .MAX_WORDS(MW), .SYNC(SY), .GAP_BITS(GB)) dut (
        .iClock(clk), .iRst_n(rst_n), .iEnable(en), .iEmpty(empty), .iRdusewd(used), .iData(data),
        .oRead(rd), .oTx(tx), .oBusy(busy), .oFrameDone(done), .oUnderrun(und));

    vlc_fifo_tx #(.CLK_DIV(1), .MAX_WORDS(4), .SYNC(SY), .GAP_BITS(2)) dut1 (
        .iClock(clk), .iRst_n(rst_n), .iEnable(en1), .iEmpty(empty1), .iRdusewd(11'd1), .iData(data1),
        .oRead(rd1), .oTx(tx1), .oBusy(busy1), .oFrameDone(done1), .oUnderrun(und1));

    int checks = 0, errors = 0;
    logic [31:0] fifo_q[$], ref_q[$];
    bit force_empty = 0, rd_seen = 0, rd1_seen = 0;
    logic tx_log[$], tx1_log[$];
    int lens[$];
    logic [15:0] syncs[$];
    int n_rd = 0, n_done = 0, n_und = 0, n_rd1 = 0, n_busy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dec(input logic q[$], input int per, input int s, input int nb);
        logic [31:0] r = 0;
        for (int i = 0; i < nb; i++) r = {r[30:0], ((s + i) * per < q.size()) ? q[(s + i) * per] : 1'bx};
        return r;
    endfunction

    task automatic upd();
        empty = fifo_q.size() == 0 || force_empty;
        used  = 11'(fifo_q.size());
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        ref_q.push_back(w);
    endtask

    // FIFO emulation: data appears the cycle after a pop.
    task automatic step();
        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) data = fifo_q.pop_front();
        if (rd1_seen) begin
            data1  = 32'h1;
            empty1 = 1;
        end
        upd();
    endtask

    task automatic wait_busy(input int max);
        int i = 0;
        while (!busy && i < max) begin step(); i++; end
        check("start_timeout", busy, 1);
    endtask

    task automatic wait_quiet(input int max);
        int i = 0, q = 0;
        while (q < 3 && i < max) begin step(); i++; q = busy ? 0 : q + 1; end
        check("quiet_timeout", q >= 3, 1);
    endtask

    // Reference model: frame position t counts cycles since the start decision.
    int t, n, nw, L, b, k;
    bit m_act = 0, m_dn = 0, m_un = 0;
    logic [31:0] words[MW];
    logic [31:0] w;
    logic [15:0] syv;
    logic [7:0] nb;
    logic e_tx, e_busy, e_rd, e_dn, e_un, bitv, prev_busy = 0, prev_busy1 = 0;

    always @(negedge clk) begin
        e_rd = 0; e_tx = 0; e_busy = 0; e_dn = m_dn; e_un = m_un; m_dn = 0; m_un = 0;
        if (!rst_n) begin
            m_act = 0; e_dn = 0; e_un = 0;
        end else if (!m_act) begin
            if (en && !empty) begin
                e_rd = 1; m_act = 1; t = 0;
                n = (used == 0) ? 1 : (int'(used) > MW ? MW : int'(used));
                nw = n;
                words[0] = ref_q.size() > 0 ? ref_q.pop_front() : 32'hx;
            end
        end else begin
            t++;
            if (t % P == 0 && t / P >= 24 && (t / P - 24) % 32 == 0) begin
                k = (t / P - 24) / 32;
                if (k < nw && k + 1 < n) begin
                    if (!empty) begin
                        e_rd = 1;
                        words[k + 1] = ref_q.size() > 0 ? ref_q.pop_front() : 32'hx;
                    end else begin
                        m_un = 1; nw = k + 1;
                    end
                end
            end
            L = 24 + 32 * nw;
            b = (t - 1) / P;
            e_busy = 1;
            if (b < L) begin
                nb = 8'(n); syv = SY;
                if (b < 16) bitv = syv[15 - b];
                else if (b < 24) bitv = nb[23 - b];
                else begin w = words[(b - 24) / 32]; bitv = w[31 - (b - 24) % 32]; end
                e_tx = ((t - 1) % P < CD) ? bitv : ~bitv;
            end
            if (t == L * P) m_dn = 1;
            if (t == (L + GB) * P) m_act = 0;
        end
        check("tx", tx, e_tx);
        check("busy", busy, e_busy);
        check("read", rd, e_rd);
        check("frame_done", done, e_dn);
        check("underrun", und, e_un);
        rd_seen = rd; rd1_seen = rd1;
        n_rd += int'(rd); n_done += int'(done); n_und += int'(und); n_rd1 += int'(rd1); n_busy += int'(busy);
        if (!rst_n) begin
            tx_log.delete(); prev_busy = 0;
        end else begin
            if (busy && !prev_busy) tx_log.delete();
            if (busy) tx_log.push_back(tx);
            if (prev_busy && !busy) begin
                lens.push_back(int'(dec(tx_log, P, 16, 8)));
                syncs.push_back(dec(tx_log, P, 0, 16));
            end
            prev_busy = busy;
            if (busy1 && !prev_busy1) tx1_log.delete();
            if (busy1) tx1_log.push_back(tx1);
            prev_busy1 = busy1;
        end
    end

    int r0, d0, u0, b0;
    logic gap_or;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 0);
        check("rst_busy", busy, 0);
        check("rst_read", rd, 0);
        rst_n = 1; en1 = 1; empty1 = 0;
        // single word frame
        push(32'hDEADBEEF); upd(); en = 1;
        wait_quiet(2000);
        check("one_reads", n_rd, 1);
        check("one_done", n_done, 1);
        check("one_busy_cycles", tx_log.size(), 512);
        check("one_sync", dec(tx_log, P, 0, 16), 16'hAAD5);
        check("one_len", dec(tx_log, P, 16, 8), 8'h01);
        check("one_word", dec(tx_log, P, 24, 32), 32'hDEADBEEF);
        gap_or = 0;
        for (int i = 448; i < 512 && i < tx_log.size(); i++) gap_or |= tx_log[i];
        check("one_gap_low", gap_or, 0);
        // fast divider, word 1
        check("div1_reads", n_rd1, 1);
        check("div1_busy_cycles", tx1_log.size(), 116);
        check("div1_sync", dec(tx1_log, 2, 0, 16), 16'hAAD5);
        if (tx1_log.size() >= 112)
            check("div1_tail", {tx1_log[108], tx1_log[109], tx1_log[110], tx1_log[111]}, 4'b0110);
        // 40 words over MAX_WORDS=16
        r0 = n_rd; d0 = n_done; lens.delete();
        for (int i = 0; i < 40; i++) push($urandom);
        upd();
        wait_quiet(20000);
        check("multi_reads", n_rd - r0, 40);
        check("multi_frames", n_done - d0, 3);
        check("multi_nlens", lens.size(), 3);
        if (lens.size() == 3) check("multi_lens", {lens[0][7:0], lens[1][7:0], lens[2][7:0]}, 24'h101008);
        // underrun after first pop
        r0 = n_rd; u0 = n_und; d0 = n_done; lens.delete();
        for (int i = 0; i < 3; i++) push($urandom);
        upd();
        for (int i = 0; i < 10 && n_rd == r0; i++) step();
        force_empty = 1; upd();
        wait_quiet(2000);
        check("und_pulses", n_und - u0, 1);
        check("und_reads", n_rd - r0, 1);
        check("und_done", n_done - d0, 1);
        check("und_busy_cycles", tx_log.size(), 512);
        if (lens.size() == 1) check("und_len", lens[0], 3);
        force_empty = 0; upd();
        wait_quiet(5000);
        // enable dropped during LEN
        d0 = n_done; lens.delete();
        for (int i = 0; i < 20; i++) push($urandom);
        upd();
        wait_busy(20);
        repeat (16 * P + 20) step();
        en = 0;
        wait_quiet(10000);
        check("en_drop_done", n_done - d0, 1);
        if (lens.size() == 1) check("en_drop_len", lens[0], 16);
        b0 = n_busy;
        repeat (300) step();
        check("en_drop_no_start", n_busy - b0, 0);
        // reset mid-DATA
        r0 = n_rd; lens.delete(); syncs.delete();
        en = 1;
        wait_busy(20);
        repeat (30 * P) step();
        #3 rst_n = 0;
        #1;
        check("arst_tx", tx, 0);
        check("arst_busy", busy, 0);
        check("arst_read", rd, 0);
        repeat (2) step();
        rst_n = 1;
        wait_busy(20);
        wait_quiet(5000);
        check("arst_reads", n_rd - r0, 4);
        if (syncs.size() == 1) check("arst_sync", syncs[0], 16'hAAD5);
        if (lens.size() == 1) check("arst_len", lens[0], 2);
        // random traffic
        en = 1;
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom % 32 == 0 && fifo_q.size() < 32) push($urandom);
            if ($urandom % 200 == 0) en = ~en;
            if ($urandom % 40 == 0) force_empty = ~force_empty;
            upd();
        end
        force_empty = 0; en = 1; upd();
        wait_quiet(40000);
        check("drain_empty", fifo_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
